// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: LFSR pattern generator / MISR compactor BIST controller for the N-bit adder top.
// Define ADDER_BIST_SIG_OUT_EN to add the diagnostic port sig (live MISR signature).
module adder_bist_ctrl #(
    parameter int           N          = 16,
    parameter int           PAT_CNT    = 256,
    parameter logic [2*N:0] LFSR_SEED  = '1,
    parameter logic [2*N:0] LFSR_TAPS  = (2*N+1)'(33'h1_0008_0000),
    parameter logic [N:0]   MISR_TAPS  = (N+1)'(17'h1_2000),
    parameter logic [N:0]   GOLDEN_SIG = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] pin_a,
    output logic [N-1:0] pin_b,
    output logic         pin_cin,
    output logic         pin_sel,
    input  logic [N-1:0] pin_sum,
`ifdef ADDER_BIST_SIG_OUT_EN
    input  logic         pin_co,
    output logic [N:0]   sig
`else
    input  logic         pin_co
`endif
);

    localparam int CW = (PAT_CNT > 2) ? $clog2(PAT_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(PAT_CNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          load;
    logic [CW-1:0] cnt;
    logic [2*N:0]  lfsr;
    logic [N:0]    misr;

    function automatic logic [2*N:0] lfsr_next(input logic [2*N:0] s);
        return {s[2*N-1:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [N:0] misr_next(input logic [N:0] m, input logic [N:0] resp);
        return {m[N-1:0], ^(m & MISR_TAPS)} ^ resp;
    endfunction

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pin_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                pin_sel = 1'b1;
                if (cnt == LAST) state_nx = CMP;
            end
            CMP: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pattern pins are a pure decode of the LFSR, gated to zero outside RUN.
    assign pin_a   = pin_sel ? lfsr[N-1:0]   : '0;
    assign pin_b   = pin_sel ? lfsr[2*N-1:N] : '0;
    assign pin_cin = pin_sel & lfsr[2*N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
            misr  <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                cnt  <= '0;
                lfsr <= LFSR_SEED;
                misr <= '0;
                pass <= 1'b0;
            end else if (state == RUN) begin
                // The adder is combinational, so the response to the current pattern is absorbed now.
                lfsr <= lfsr_next(lfsr);
                misr <= misr_next(misr, {pin_co, pin_sum});
                if (cnt != LAST) cnt <= cnt + 1'b1;
            end else if (state == CMP) begin
                pass <= (misr == GOLDEN_SIG);
            end
        end
    end

`ifdef ADDER_BIST_SIG_OUT_EN
    assign sig = misr;
`endif

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Scoreboard bench for adder_bist_ctrl (N=4, PAT_CNT=8) with a behavioural adder and LFSR/MISR reference model.
module tb_adder_bist_ctrl;

    localparam int         N     = 4;
    localparam int         PAT   = 8;
    localparam logic [8:0] SEED  = 9'h1FF;
    localparam logic [8:0] LTAPS = 9'h110;
    localparam logic [4:0] MTAPS = 5'h14;

    // k-th pattern: the seed advanced k times by the shift-with-parity rule.
    function automatic logic [8:0] ref_pattern(input int k);
        logic [8:0] s;
        s = SEED;
        for (int i = 0; i < k; i++) s = {s[7:0], ^(s & LTAPS)};
        return s;
    endfunction

    // Final signature of a full run; fault_k < 0 means no fault injected.
    function automatic logic [4:0] ref_signature(input int fault_k);
        logic [8:0] p;
        logic [4:0] m;
        logic [4:0] r;
        m = '0;
        for (int k = 0; k < PAT; k++) begin
            p = ref_pattern(k);
            r = 5'(p[3:0]) + 5'(p[7:4]) + 5'(p[8]);
            if (k == fault_k) r[0] = ~r[0];
            m = {m[3:0], ^(m & MTAPS)} ^ r;
        end
        return m;
    endfunction

    localparam logic [4:0] GOLD = ref_signature(-1);

    typedef struct {
        logic       pass;
        int         done_edge;
        logic [4:0] sig;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy, done, pass;
    logic [N-1:0] pin_a, pin_b, pin_sum;
    logic         pin_cin, pin_sel, pin_co;
`ifdef ADDER_BIST_SIG_OUT_EN
    logic [N:0]   sig;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    logic fault_en = 1'b0;
    int   fault_k  = -1;
    logic done_prev = 1'b0;
    res_t       res_q[$];
    logic [8:0] pat_q[$];

    adder_bist_ctrl #(
        .N(N), .PAT_CNT(PAT), .LFSR_SEED(SEED), .LFSR_TAPS(LTAPS),
        .MISR_TAPS(MTAPS), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .pin_a(pin_a), .pin_b(pin_b), .pin_cin(pin_cin), .pin_sel(pin_sel),
        .pin_sum(pin_sum),
`ifdef ADDER_BIST_SIG_OUT_EN
        .pin_co(pin_co), .sig(sig)
`else
        .pin_co(pin_co)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Adder top stand-in, with an optional single-bit fault on one chosen pattern.
    always_comb begin
        {pin_co, pin_sum} = 5'(pin_a) + 5'(pin_b) + 5'(pin_cin);
        if (fault_en && pin_sel && ({pin_cin, pin_b, pin_a} == ref_pattern(fault_k)))
            pin_sum[0] = ~pin_sum[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pin_sel) begin
            if (pat_q.size() == 0) check("unexpected_run_cycle", 32'(pin_sel), 32'h0);
            else check("pattern", 32'({pin_cin, pin_b, pin_a}), 32'(pat_q.pop_front()));
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("pass", 32'(pass), 32'(r.pass));
                check("done_latency", 32'(edge_n), 32'(r.done_edge));
                check("run_length", 32'(pat_q.size()), 32'h0);
`ifdef ADDER_BIST_SIG_OUT_EN
                check("sig", 32'(sig), 32'(r.sig));
`endif
            end
        end
        done_prev = done;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_pins"}, 32'({pin_sel, pin_cin, pin_b, pin_a}), 32'h0);
`ifdef ADDER_BIST_SIG_OUT_EN
        check({tag, "_sig"}, 32'(sig), 32'h0);
`endif
    endtask

    task automatic launch(input int fk);
        res_t e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.pass      = (fk < 0) ? 1'b1 : (ref_signature(fk) == GOLD);
        e.done_edge = edge_n + PAT + 1;
        e.sig       = ref_signature(fk);
        res_q.push_back(e);
        for (int k = 0; k < PAT; k++) pat_q.push_back(ref_pattern(k));
        fault_k  = fk;
        fault_en = (fk >= 0);
        check("launch_busy", 32'(busy), 32'h1);
        check("launch_done_clr", 32'({done, pass}), 32'h0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (res_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (res_q.size() != 0) begin
            check("done_timeout", 32'(res_q.size()), 32'h0);
            res_q.delete();
            pat_q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Golden run straight after reset.
        launch(-1);
        wait_done();

        // Fault on pattern 3, started from DONE.
        launch(3);
        wait_done();

        // Randomised fault positions and idle gaps.
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            launch(int'($urandom_range(0, PAT - 1)));
            wait_done();
        end

        // A start pulse in RUN cycle 4 must be ignored.
        launch(-1);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Reset in RUN cycle 5 aborts the run.
        launch(-1);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        res_q.delete();
        pat_q.delete();
        fault_en = 1'b0;
        check_idle_outputs("midrun_rst");
        launch(-1);
        wait_done();

        // Restart from DONE repeats the identical result.
        launch(-1);
        wait_done();

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check_idle_outputs("rst_vs_start");
        repeat (3) begin @(posedge clk); #1; end
        check("rst_vs_start_stays_idle", 32'({busy, done}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
